// File: rtl/id_ex_operand_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage_if
// Bundle between the ID stage and the ID/EX operand stage.
//   ID side (master drives): valid_ID, read{1,2}Data_ID, read{1,2}RegSel_ID,
//     use{1,2}_ID, Write_register_ID, RegWrite_ID, MemRead_ID, link_ID,
//     line{1,2}_EXEX, line{1,2}_MEMEX, fwd_data_MEM, fwd_data_WB,
//     stall_in, flush_in
//   EX side (slave drives): stall_ID, opA_EX, opB_EX, valid_EX, RegWrite_EX,
//     MemRead_EX, link_EX, Write_register_EX, lu_stall_cnt
// ---------------------------------------------------------------------------
interface id_ex_operand_stage_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
);
    logic             valid_ID;
    logic [WIDTH-1:0] read1Data_ID;
    logic [WIDTH-1:0] read2Data_ID;
    logic [2:0]       read1RegSel_ID;
    logic [2:0]       read2RegSel_ID;
    logic             use1_ID;
    logic             use2_ID;
    logic [2:0]       Write_register_ID;
    logic             RegWrite_ID;
    logic             MemRead_ID;
    logic             link_ID;
    logic             line1_EXEX;
    logic             line2_EXEX;
    logic             line1_MEMEX;
    logic             line2_MEMEX;
    logic [WIDTH-1:0] fwd_data_MEM;
    logic [WIDTH-1:0] fwd_data_WB;
    logic             stall_in;
    logic             flush_in;

    logic             stall_ID;
    logic [WIDTH-1:0] opA_EX;
    logic [WIDTH-1:0] opB_EX;
    logic             valid_EX;
    logic             RegWrite_EX;
    logic             MemRead_EX;
    logic             link_EX;
    logic [2:0]       Write_register_EX;
    logic [CNT_W-1:0] lu_stall_cnt;

    modport master (
        output valid_ID, read1Data_ID, read2Data_ID, read1RegSel_ID, read2RegSel_ID,
               use1_ID, use2_ID, Write_register_ID, RegWrite_ID, MemRead_ID, link_ID,
               line1_EXEX, line2_EXEX, line1_MEMEX, line2_MEMEX,
               fwd_data_MEM, fwd_data_WB, stall_in, flush_in,
        input  stall_ID, opA_EX, opB_EX, valid_EX, RegWrite_EX, MemRead_EX, link_EX,
               Write_register_EX, lu_stall_cnt
    );

    modport slave (
        input  valid_ID, read1Data_ID, read2Data_ID, read1RegSel_ID, read2RegSel_ID,
               use1_ID, use2_ID, Write_register_ID, RegWrite_ID, MemRead_ID, link_ID,
               line1_EXEX, line2_EXEX, line1_MEMEX, line2_MEMEX,
               fwd_data_MEM, fwd_data_WB, stall_in, flush_in,
        output stall_ID, opA_EX, opB_EX, valid_EX, RegWrite_EX, MemRead_EX, link_EX,
               Write_register_EX, lu_stall_cnt
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
// ID/EX pipeline register with EX operand resolution, load-use hazard
// detection, freeze/flush handling and a saturating load-use stall counter.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (registers -> bubble, counter -> 0)
//   bus    id_ex_operand_stage_if.slave: ID-side inputs, EX-side outputs
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    id_ex_operand_stage_if.slave bus
);

    // EX-stage registers
    logic             r_valid;
    logic             r_regwrite;
    logic             r_memread;
    logic             r_link;
    logic [2:0]       r_wreg;
    logic [WIDTH-1:0] r_rd1;
    logic [WIDTH-1:0] r_rd2;
    logic             r_l1_exex;
    logic             r_l2_exex;
    logic             r_l1_memex;
    logic             r_l2_memex;
    logic [CNT_W-1:0] r_cnt;

    logic w_haz;
    logic w_stall_id;
    logic w_bubble;
    logic w_capture;

    // A load in EX whose destination is read by the real instruction in ID.
    assign w_haz = r_valid & r_memread & r_regwrite & bus.valid_ID &
                   ((bus.use1_ID & (bus.read1RegSel_ID == r_wreg)) |
                    (bus.use2_ID & (bus.read2RegSel_ID == r_wreg)));

    // A freeze or redirect already covers the ID instruction, so no stall request.
    assign w_stall_id = w_haz & ~bus.stall_in & ~bus.flush_in;

    // Flush beats freeze; freeze beats hazard bubble.
    assign w_bubble  = bus.flush_in | (~bus.stall_in & w_haz);
    assign w_capture = ~bus.flush_in & ~bus.stall_in & ~w_haz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_link     <= 1'b0;
            r_wreg     <= 3'd0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_l1_exex  <= 1'b0;
            r_l2_exex  <= 1'b0;
            r_l1_memex <= 1'b0;
            r_l2_memex <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_bubble) begin
                r_valid    <= 1'b0;
                r_regwrite <= 1'b0;
                r_memread  <= 1'b0;
                r_link     <= 1'b0;
                r_wreg     <= 3'd0;
                r_rd1      <= '0;
                r_rd2      <= '0;
                r_l1_exex  <= 1'b0;
                r_l2_exex  <= 1'b0;
                r_l1_memex <= 1'b0;
                r_l2_memex <= 1'b0;
            end else if (w_capture) begin
                r_valid    <= bus.valid_ID;
                r_regwrite <= bus.RegWrite_ID;
                r_memread  <= bus.MemRead_ID;
                r_link     <= bus.link_ID;
                r_wreg     <= bus.Write_register_ID;
                r_rd1      <= bus.read1Data_ID;
                r_rd2      <= bus.read2Data_ID;
                r_l1_exex  <= bus.line1_EXEX;
                r_l2_exex  <= bus.line2_EXEX;
                r_l1_memex <= bus.line1_MEMEX;
                r_l2_memex <= bus.line2_MEMEX;
            end
            // Saturate at all-ones rather than wrap.
            if (w_stall_id && !(&r_cnt)) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Operand mux: EX-EX forward wins over MEM-EX, which wins over latched data.
    always_comb begin
        bus.opA_EX = r_rd1;
        if (r_l1_exex) begin
            bus.opA_EX = bus.fwd_data_MEM;
        end else if (r_l1_memex) begin
            bus.opA_EX = bus.fwd_data_WB;
        end

        bus.opB_EX = r_rd2;
        if (r_l2_exex) begin
            bus.opB_EX = bus.fwd_data_MEM;
        end else if (r_l2_memex) begin
            bus.opB_EX = bus.fwd_data_WB;
        end
    end

    assign bus.stall_ID          = w_stall_id;
    assign bus.valid_EX          = r_valid;
    assign bus.RegWrite_EX       = r_regwrite;
    assign bus.MemRead_EX        = r_memread;
    assign bus.link_EX           = r_link;
    assign bus.Write_register_EX = r_wreg;
    assign bus.lu_stall_cnt      = r_cnt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_operand_stage
// Directed vectors; each cycle the driver applies ID-side inputs and pushes
// the hand-computed outputs expected for that cycle into a scoreboard queue.
// A monitor pops and compares mid-cycle, away from the clock edge.
// ---------------------------------------------------------------------------
module tb_id_ex_operand_stage;

    logic clk;
    logic rst_n;

    id_ex_operand_stage_if #(.WIDTH(16), .CNT_W(4)) bus ();

    id_ex_operand_stage #(.WIDTH(16), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic        v;
        logic [15:0] d1, d2;
        logic [2:0]  s1, s2;
        logic        u1, u2;
        logic [2:0]  wr;
        logic        rw, mr, lk;
        logic        e1, e2, m1, m2;
        logic [15:0] fm, fw;
        logic        st, fl;
    } in_t;

    typedef struct {
        string       nm;
        logic        stall;
        logic [15:0] a, b;
        logic        v, rw, mr, lk;
        logic [2:0]  wr;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic in_t ins(logic v, logic [15:0] d1, logic [15:0] d2, logic [2:0] s1,
                                logic [2:0] s2, logic u1, logic u2, logic [2:0] wr,
                                logic rw, logic mr, logic lk);
        in_t i;
        i.rn = 1'b1; i.v = v; i.d1 = d1; i.d2 = d2; i.s1 = s1; i.s2 = s2;
        i.u1 = u1; i.u2 = u2; i.wr = wr; i.rw = rw; i.mr = mr; i.lk = lk;
        i.e1 = 1'b0; i.e2 = 1'b0; i.m1 = 1'b0; i.m2 = 1'b0;
        i.fm = 16'h0; i.fw = 16'h0; i.st = 1'b0; i.fl = 1'b0;
        return i;
    endfunction

    function automatic exp_t ex(string nm, logic stall, logic [15:0] a, logic [15:0] b,
                                logic v, logic rw, logic mr, logic lk, logic [2:0] wr,
                                logic [3:0] cnt);
        exp_t e;
        e.nm = nm; e.stall = stall; e.a = a; e.b = b; e.v = v; e.rw = rw;
        e.mr = mr; e.lk = lk; e.wr = wr; e.cnt = cnt;
        return e;
    endfunction

    function automatic exp_t zx(string nm, logic [3:0] cnt);
        return ex(nm, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, cnt);
    endfunction

    function automatic logic [3:0] sat(int k);
        return (k > 15) ? 4'hF : 4'(k);
    endfunction

    task automatic drive(input in_t i);
        rst_n                 = i.rn;
        bus.valid_ID          = i.v;
        bus.read1Data_ID      = i.d1;
        bus.read2Data_ID      = i.d2;
        bus.read1RegSel_ID    = i.s1;
        bus.read2RegSel_ID    = i.s2;
        bus.use1_ID           = i.u1;
        bus.use2_ID           = i.u2;
        bus.Write_register_ID = i.wr;
        bus.RegWrite_ID       = i.rw;
        bus.MemRead_ID        = i.mr;
        bus.link_ID           = i.lk;
        bus.line1_EXEX        = i.e1;
        bus.line2_EXEX        = i.e2;
        bus.line1_MEMEX       = i.m1;
        bus.line2_MEMEX       = i.m2;
        bus.fwd_data_MEM      = i.fm;
        bus.fwd_data_WB       = i.fw;
        bus.stall_in          = i.st;
        bus.flush_in          = i.fl;
    endtask

    // Apply inputs just after the edge and queue what this cycle must show.
    task automatic cyc(input in_t i, input exp_t e);
        @(posedge clk);
        #2;
        drive(i);
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input string fld, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, exp);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.nm, "stall_ID", {15'd0, bus.stall_ID}, {15'd0, e.stall});
                chk(e.nm, "opA_EX", bus.opA_EX, e.a);
                chk(e.nm, "opB_EX", bus.opB_EX, e.b);
                chk(e.nm, "valid_EX", {15'd0, bus.valid_EX}, {15'd0, e.v});
                chk(e.nm, "RegWrite_EX", {15'd0, bus.RegWrite_EX}, {15'd0, e.rw});
                chk(e.nm, "MemRead_EX", {15'd0, bus.MemRead_EX}, {15'd0, e.mr});
                chk(e.nm, "link_EX", {15'd0, bus.link_EX}, {15'd0, e.lk});
                chk(e.nm, "Write_register_EX", {13'd0, bus.Write_register_EX}, {13'd0, e.wr});
                chk(e.nm, "lu_stall_cnt", {12'd0, bus.lu_stall_cnt}, {12'd0, e.cnt});
            end
        end
    end

    // Driver / stimulus
    initial begin
        in_t i;
        in_t lds;
        i = ins(1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        i.rn = 1'b0;
        drive(i);

        // Reset, release, then reset again in the middle of traffic
        cyc(i, zx("rst_hold", 4'd0));
        i = ins(1'b1, 16'h1234, 16'h5678, 3'd1, 3'd2, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
        cyc(i, zx("rst_rel", 4'd0));
        i = ins(1'b1, 16'h0AAA, 16'h0BBB, 3'd5, 3'd6, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1);
        cyc(i, ex("pipe_a", 1'b0, 16'h1234, 16'h5678, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 4'd0));
        i = ins(1'b1, 16'h3333, 16'h4444, 3'd1, 3'd1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
        i.rn = 1'b0;
        cyc(i, zx("rst_mid0", 4'd0));
        cyc(i, zx("rst_mid1", 4'd0));
        cyc(i, zx("rst_mid2", 4'd0));
        i = ins(1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc(i, zx("rst_off", 4'd0));

        // EX-EX forward, then EX-EX over MEM-EX
        i = ins(1'b1, 16'h1111, 16'h2222, 3'd1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        i.e1 = 1'b1;
        cyc(i, zx("rst_first_edge", 4'd0));
        i.m1 = 1'b1; i.fm = 16'hBEEF; i.fw = 16'h5555;
        cyc(i, ex("exex", 1'b0, 16'hBEEF, 16'h2222, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 4'd0));
        i = ins(1'b1, 16'h0010, 16'h0, 3'd1, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
        i.fm = 16'hBEEF; i.fw = 16'h5555;
        cyc(i, ex("exex_over_memex", 1'b0, 16'hBEEF, 16'h2222, 1'b1, 1'b1, 1'b0, 1'b0,
                  3'd3, 4'd0));

        // Load-use on line 2, one bubble, then MEM-EX forward of the load data
        i = ins(1'b1, 16'h0001, 16'h0, 3'd1, 3'd3, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
        i.e2 = 1'b1;
        cyc(i, ex("lu_stall", 1'b1, 16'h0010, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 4'd0));
        i.e2 = 1'b0; i.m2 = 1'b1; i.fw = 16'h00A5; i.fm = 16'h0777;
        cyc(i, zx("lu_bubble", 4'd1));
        i = ins(1'b1, 16'h4444, 16'h5555, 3'd6, 3'd7, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1);
        i.e1 = 1'b1; i.fw = 16'h00A5; i.fm = 16'h0777;
        cyc(i, ex("lu_fwd", 1'b0, 16'h0001, 16'h00A5, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 4'd1));

        // Four-cycle freeze; opA keeps following fwd_data_MEM live
        i = ins(1'b1, 16'h9999, 16'h8888, 3'd0, 3'd0, 1'b0, 1'b0, 3'd6, 1'b1, 1'b1, 1'b0);
        i.st = 1'b1;
        i.fm = 16'h1234;
        cyc(i, ex("frz0", 1'b0, 16'h1234, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 4'd1));
        i.fm = 16'h2345;
        cyc(i, ex("frz1", 1'b0, 16'h2345, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 4'd1));
        i.fm = 16'h3456;
        cyc(i, ex("frz2", 1'b0, 16'h3456, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 4'd1));
        i.fm = 16'h4567;
        cyc(i, ex("frz3", 1'b0, 16'h4567, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 4'd1));
        i = ins(1'b1, 16'h0020, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
        i.fm = 16'h5678;
        cyc(i, ex("frz_end", 1'b0, 16'h5678, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 4'd1));

        // Flush with hazard, then flush with freeze and hazard
        i = ins(1'b1, 16'h0099, 16'h0, 3'd2, 3'd0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
        i.fl = 1'b1;
        cyc(i, ex("flush_haz", 1'b0, 16'h0020, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 4'd1));
        i = ins(1'b1, 16'h0030, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
        cyc(i, zx("flush_bub", 4'd1));
        i = ins(1'b1, 16'h0099, 16'h0, 3'd2, 3'd0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
        i.st = 1'b1; i.fl = 1'b1;
        cyc(i, ex("flush_frz", 1'b0, 16'h0030, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 4'd1));
        i = ins(1'b1, 16'h0040, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);
        cyc(i, zx("flush_over_frz", 4'd1));

        // Register numbers match but neither line is used: no stall
        i = ins(1'b1, 16'h00C3, 16'h00D4, 3'd2, 3'd2, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
        cyc(i, ex("no_false", 1'b0, 16'h0040, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 4'd1));
        i = ins(1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc(i, ex("no_false_cap", 1'b0, 16'h00C3, 16'h00D4, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5,
                  4'd1));

        // Back-to-back dependent loads: 20 hazards, counter stops at 0xF
        lds = ins(1'b1, 16'h0050, 16'h0, 3'd1, 3'd0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0);
        cyc(lds, zx("sat_pre", 4'd1));
        for (int k = 1; k <= 20; k++) begin
            cyc(lds, ex("sat_stall", 1'b1, 16'h0050, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1,
                        sat(k)));
            cyc(lds, zx("sat_bub", sat(k + 1)));
        end
        cyc(i, ex("sat_final", 1'b0, 16'h0050, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 4'hF));

        for (int w = 0; w < 5 && sb.size() > 0; w++) @(posedge clk);
        #5;
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and EX operand resolution for the 5-stage 16-bit pipeline. Latches decoded operands, control and the four EX-EX/MEM-EX forwarding select lines computed in ID. In EX it drives the final ALU operands from the register-file value, the MEM-stage result or the WB-stage data. Also owns load-use hazard detection (one-cycle ID stall plus EX bubble), global freeze and flush handling, and a saturating load-use stall counter.

## Interface
- WIDTH, 16, data path width
- CNT_W, 16, stall counter width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_ID  in  1  ID holds a real instruction
- read1Data_ID, read2Data_ID  in  WIDTH  register-file read data
- read1RegSel_ID, read2RegSel_ID  in  3  source register numbers
- use1_ID, use2_ID  in  1  instruction actually reads line 1 / line 2
- Write_register_ID  in  3  destination register
- RegWrite_ID, MemRead_ID, link_ID  in  1  decoded control
- line1_EXEX, line2_EXEX, line1_MEMEX, line2_MEMEX  in  1  forwarding selects computed in ID
- fwd_data_MEM  in  WIDTH  result held in the EX/MEM register
- fwd_data_WB  in  WIDTH  write-back data
- stall_in  in  1  global freeze from memory
- flush_in  in  1  branch/jump redirect; kills the instruction in ID
- stall_ID  out  1  load-use stall request to PC/IF-ID
- opA_EX, opB_EX  out  WIDTH  resolved ALU operands
- valid_EX, RegWrite_EX, MemRead_EX, link_EX  out  1  registered control
- Write_register_EX  out  3  registered destination
- lu_stall_cnt  out  CNT_W  load-use stall count

## Operation
- Load-use hazard (combinational): haz = valid_EX & MemRead_EX & RegWrite_EX & valid_ID & ((use1_ID & read1RegSel_ID == Write_register_EX) | (use2_ID & read2RegSel_ID == Write_register_EX)).
- stall_ID = haz & ~stall_in & ~flush_in.
- Register update each edge, highest priority first:
  - flush_in: load bubble.
  - stall_in: hold all registers.
  - haz: load bubble.
  - Otherwise: capture ID inputs.
- Bubble: valid, RegWrite, MemRead, link and all four forwarding flags = 0; data and register fields = 0.
- Operand mux, per line: EXEX flag selects fwd_data_MEM. Else MEMEX flag selects fwd_data_WB. Else the latched register data is used. EXEX wins when both flags are set.
- After a load-use bubble, the load reaches MEM on the next cycle. The forwarding unit then asserts MEMEX for the held ID instruction, so a single bubble is always sufficient.
- lu_stall_cnt increments by 1 on each edge where stall_ID = 1. It saturates at all-ones and never wraps.

## Timing
- Reset (async assert, any cycle) forces all registers to bubble and lu_stall_cnt to 0.
- After reset, all outputs are 0, including opA_EX and opB_EX; stall_ID = 0.
- Release of rst_n is sampled at the next rising edge.
- Latency: ID inputs appear on the EX outputs one cycle later. opA_EX and opB_EX are combinational from registers plus fwd_data_MEM and fwd_data_WB in the same cycle.
- Load-use stall lasts exactly one cycle per hazard. Back-to-back dependent loads each cost one cycle.
- stall_in held N cycles freezes the EX registers N cycles. The operand mux keeps tracking fwd_data_* live during the freeze.
- flush_in together with haz or stall_in: a bubble is loaded, stall_ID = 0 and the counter does not increment.
- A reset asserted mid-stall clears the stall immediately; no residual stall follows reset release.

## Test plan
- Reset mid-run: rst_n low for 3 cycles with valid traffic -> all outputs 0 and lu_stall_cnt 0 during reset and on the first edge after release.
- EX-EX forward: ID has line1_EXEX=1, read1Data_ID=0x1111; next cycle fwd_data_MEM=0xBEEF -> opA_EX=0xBEEF. With line1_MEMEX also 1 and fwd_data_WB=0x5555 -> still 0xBEEF.
- Load-use: LD r3 in EX (MemRead_EX=1, Write_register_EX=3), ID ADD reads r3 on line 2 -> stall_ID=1 for exactly one cycle, valid_EX=0 next cycle, lu_stall_cnt=1. The ADD then enters EX with line2_MEMEX=1 and fwd_data_WB=0x00A5 -> opB_EX=0x00A5.
- Freeze/flush priority: stall_in=1 for 4 cycles -> EX outputs unchanged. flush_in=1 with haz=1 -> bubble loaded, stall_ID=0, counter unchanged.
- Counter saturation: with CNT_W=4, force 20 load-use hazards -> lu_stall_cnt stops at 0xF.
- No false stall: load in EX writes r2, ID reads r2 with use1_ID=use2_ID=0 -> stall_ID=0 and the ID instruction is captured next cycle.
